// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : MIPS instruction-fetch stage: PC register, ROM address/enable,
//            and IF/ID pipeline register with stall, branch and flush handling.
// Options  : IF_ALIGN_CHECK_EN adds id_excpt_adel_o misaligned-fetch tagging.
// Revision : 1.0
// ============================================================================
module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_pc_i,
  input  logic              stall_if_i,
  input  logic              stall_id_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] id_pc_o,
`ifdef IF_ALIGN_CHECK_EN
  output logic              id_excpt_adel_o,
`endif
  output logic [INST_W-1:0] id_inst_o
);

  localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(4);

  logic              r_ce;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_id_pc;
  logic [INST_W-1:0] r_id_inst;
  logic [INST_W-1:0] w_cap_inst;

`ifdef IF_ALIGN_CHECK_EN
  logic r_id_adel;
  logic w_misaligned;

  assign w_misaligned = (r_pc[1:0] != 2'b00);
  // A misaligned fetch never reaches the ROM; it is tagged as AdEL in IF/ID.
  assign w_cap_inst   = w_misaligned ? '0 : rom_inst_i;
  assign rom_ce_o     = r_ce & ~w_misaligned;
  assign id_excpt_adel_o = r_id_adel;
`else
  assign w_cap_inst   = rom_inst_i;
  assign rom_ce_o     = r_ce;
`endif

  assign rom_addr_o = r_pc;
  assign id_pc_o    = r_id_pc;
  assign id_inst_o  = r_id_inst;

  // Fetch enable and program counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ce <= 1'b0;
      r_pc <= RESET_PC;
    end else begin
      r_ce <= 1'b1;
      if (r_ce) begin
        if (flush_i) begin
          r_pc <= new_pc_i;
        end else if (stall_pc_i) begin
          r_pc <= r_pc;
        end else if (branch_flag_i) begin
          r_pc <= branch_target_i;
        end else begin
          r_pc <= r_pc + c_pc_step;
        end
      end
    end
  end

  // IF/ID register: a stalled IF with a running ID must hand ID a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_pc   <= '0;
      r_id_inst <= '0;
    end else if (flush_i || (stall_if_i && !stall_id_i)) begin
      r_id_pc   <= '0;
      r_id_inst <= '0;
    end else if (!stall_if_i) begin
      r_id_pc   <= r_pc;
      r_id_inst <= w_cap_inst;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_adel <= 1'b0;
    end else if (flush_i || (stall_if_i && !stall_id_i)) begin
      r_id_adel <= 1'b0;
    end else if (!stall_if_i) begin
      r_id_adel <= w_misaligned;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// Directed self-checking bench for if_fetch_stage with a small combinational ROM model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_pc, stall_if, stall_id, branch_flag, flush;
  logic [31:0] branch_target, new_pc, rom_inst, rom_addr, id_pc, id_inst;
  logic        rom_ce;
`ifdef IF_ALIGN_CHECK_EN
  logic        id_adel;
`endif

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ROM returns zero while disabled, indexed by word address.
  assign rom_inst = rom_ce ? mem[rom_addr[7:2]] : 32'h0;

  if_fetch_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .stall_pc_i(stall_pc), .stall_if_i(stall_if), .stall_id_i(stall_id),
    .branch_flag_i(branch_flag), .branch_target_i(branch_target),
    .flush_i(flush), .new_pc_i(new_pc), .rom_inst_i(rom_inst),
    .rom_addr_o(rom_addr), .rom_ce_o(rom_ce), .id_pc_o(id_pc),
`ifdef IF_ALIGN_CHECK_EN
    .id_excpt_adel_o(id_adel),
`endif
    .id_inst_o(id_inst)
  );

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b expected 0", rom_ce); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", rom_addr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst: got %h expected 0", id_inst); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    checks++; if (rom_ce !== 1'b1) begin errors++; $display("FAIL fetch_ce: got %b expected 1", rom_ce); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL fetch_addr0: got %h expected 0", rom_addr); end
    checks++; if (id_inst !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL fetch_nop: got %h/%h expected 0/0", id_pc, id_inst); end
    @(negedge clk);
    checks++; if (rom_addr !== 32'h4) begin errors++; $display("FAIL fetch_addr4: got %h expected 4", rom_addr); end
    checks++; if (id_pc !== 32'h0 || id_inst !== 32'h34011100) begin errors++; $display("FAIL fetch_id0: got %h/%h expected 0/34011100", id_pc, id_inst); end
    @(negedge clk);
    checks++; if (rom_addr !== 32'h8) begin errors++; $display("FAIL fetch_addr8: got %h expected 8", rom_addr); end
    checks++; if (id_pc !== 32'h4 || id_inst !== 32'h34020020) begin errors++; $display("FAIL fetch_id4: got %h/%h expected 4/34020020", id_pc, id_inst); end
  endtask

  task automatic test_bubble_stall();
    stall_pc = 1'b1; stall_if = 1'b1; stall_id = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (rom_addr !== 32'h8) begin errors++; $display("FAIL bubble_pc_hold: got %h expected 8", rom_addr); end
      checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0) begin errors++; $display("FAIL bubble_id: got %h/%h expected 0/0", id_pc, id_inst); end
    end
    stall_pc = 1'b0; stall_if = 1'b0;
    @(negedge clk);
    checks++; if (id_pc !== 32'h8 || id_inst !== mem[2]) begin errors++; $display("FAIL bubble_release: got %h/%h expected 8/%h", id_pc, id_inst, mem[2]); end
    checks++; if (rom_addr !== 32'hC) begin errors++; $display("FAIL bubble_next_addr: got %h expected c", rom_addr); end
  endtask

  task automatic test_hold_stall();
    stall_pc = 1'b1; stall_if = 1'b1; stall_id = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (id_pc !== 32'h8 || id_inst !== mem[2]) begin errors++; $display("FAIL hold_id: got %h/%h expected 8/%h", id_pc, id_inst, mem[2]); end
      checks++; if (rom_addr !== 32'hC) begin errors++; $display("FAIL hold_pc: got %h expected c", rom_addr); end
    end
    stall_pc = 1'b0; stall_if = 1'b0; stall_id = 1'b0;
    @(negedge clk);
    checks++; if (id_pc !== 32'hC || rom_addr !== 32'h10) begin errors++; $display("FAIL hold_release: got %h/%h expected c/10", id_pc, rom_addr); end
  endtask

  task automatic test_branch();
    branch_flag = 1'b1; branch_target = 32'h40;
    @(negedge clk);
    branch_flag = 1'b0;
    checks++; if (rom_addr !== 32'h40) begin errors++; $display("FAIL branch_addr: got %h expected 40", rom_addr); end
    checks++; if (id_pc !== 32'h10 || id_inst !== mem[4]) begin errors++; $display("FAIL branch_delay_slot: got %h/%h expected 10/%h", id_pc, id_inst, mem[4]); end
    @(negedge clk);
    checks++; if (id_pc !== 32'h40 || id_inst !== mem[16]) begin errors++; $display("FAIL branch_target_id: got %h/%h expected 40/%h", id_pc, id_inst, mem[16]); end
    checks++; if (rom_addr !== 32'h44) begin errors++; $display("FAIL branch_seq: got %h expected 44", rom_addr); end
  endtask

  task automatic test_flush();
    flush = 1'b1; new_pc = 32'h20; branch_flag = 1'b1; branch_target = 32'h80; stall_pc = 1'b1;
    @(negedge clk);
    flush = 1'b0; branch_flag = 1'b0; stall_pc = 1'b0;
    checks++; if (rom_addr !== 32'h20) begin errors++; $display("FAIL flush_pc: got %h expected 20", rom_addr); end
    checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0) begin errors++; $display("FAIL flush_id: got %h/%h expected 0/0", id_pc, id_inst); end
    @(negedge clk);
    checks++; if (id_pc !== 32'h20 || id_inst !== mem[8]) begin errors++; $display("FAIL flush_resume: got %h/%h expected 20/%h", id_pc, id_inst, mem[8]); end
  endtask

  task automatic test_async_reset();
    branch_flag = 1'b1; branch_target = 32'h1C;
    @(negedge clk);
    branch_flag = 1'b0;
    checks++; if (rom_addr !== 32'h1C) begin errors++; $display("FAIL areset_setup: got %h expected 1c", rom_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rom_ce !== 1'b0 || rom_addr !== 32'h0) begin errors++; $display("FAIL areset_pc: got ce=%b addr=%h expected 0/0", rom_ce, rom_addr); end
    checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0) begin errors++; $display("FAIL areset_id: got %h/%h expected 0/0", id_pc, id_inst); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin errors++; $display("FAIL areset_restart: got ce=%b addr=%h expected 1/0", rom_ce, rom_addr); end
    @(negedge clk);
    checks++; if (id_pc !== 32'h0 || id_inst !== 32'h34011100) begin errors++; $display("FAIL areset_first: got %h/%h expected 0/34011100", id_pc, id_inst); end
  endtask

  task automatic test_wrap();
    branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_flag = 1'b0;
    @(negedge clk);
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", rom_addr); end
    checks++; if (id_pc !== 32'hFFFF_FFFC || id_inst !== mem[63]) begin errors++; $display("FAIL wrap_id: got %h/%h expected fffffffc/%h", id_pc, id_inst, mem[63]); end
  endtask

`ifdef IF_ALIGN_CHECK_EN
  task automatic test_align();
    branch_flag = 1'b1; branch_target = 32'h42;
    @(negedge clk);
    branch_flag = 1'b0;
    checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL align_ce: got %b expected 0", rom_ce); end
    @(negedge clk);
    checks++; if (id_adel !== 1'b1 || id_pc !== 32'h42 || id_inst !== 32'h0) begin errors++; $display("FAIL align_id: got %b/%h/%h expected 1/42/0", id_adel, id_pc, id_inst); end
    flush = 1'b1; new_pc = 32'h0;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (id_adel !== 1'b0 || rom_ce !== 1'b1) begin errors++; $display("FAIL align_flush: got adel=%b ce=%b expected 0/1", id_adel, rom_ce); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h34011100;
    mem[1] = 32'h34020020;
    stall_pc = 1'b0; stall_if = 1'b0; stall_id = 1'b0;
    branch_flag = 1'b0; branch_target = '0; flush = 1'b0; new_pc = '0;
    #2 rst = 1'b1;
    test_reset();
    test_fetch();
    test_bubble_stall();
    test_hold_stall();
    test_branch();
    test_flush();
    test_async_reset();
    test_wrap();
`ifdef IF_ALIGN_CHECK_EN
    test_align();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
